// File: rtl/sqrt_goldschmidt_unit.sv
// sqrt_goldschmidt_unit
//   Iterative Goldschmidt square root (optionally reciprocal square root) of a
//   normalised significand 1.(MANT_W-1). Applies the odd-exponent sqrt(2)
//   correction, renormalises, rounds half-up and reports the result with a
//   busy/valid handshake.
//
//   Optional feature macro: SQRT_RSQRT_EN
//     defined   : mode_i selects sqrt (0) or reciprocal sqrt (1)
//     undefined : sqrt only; mode_i ignored, norm_o tied 0
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   doSqrt_i      start request, sampled only while idle
//   s_i           significand in [1,2), MSB set
//   is_exp_odd_i  scale result by sqrt(2) (sqrt) or 1/sqrt(2) (rsqrt)
//   mode_i        0 = sqrt, 1 = reciprocal sqrt
//   busy_o        operation in progress
//   valid_o       one-cycle result strobe
//   res_o         rounded normalised result 1.(MANT_W-1)
//   norm_o        result was shifted left by one (packer decrements exponent)
//   iter_o        Goldschmidt iterations executed for this result
module sqrt_goldschmidt_unit #(
  parameter int MANT_W   = 8,
  parameter int PREC_W   = 8,
  parameter int ITER_MAX = 4,
  localparam int IW      = $clog2(ITER_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              doSqrt_i,
  input  logic [MANT_W-1:0] s_i,
  input  logic              is_exp_odd_i,
  input  logic              mode_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [MANT_W-1:0] res_o,
  output logic              norm_o,
  output logic [IW-1:0]     iter_o
);

  // Internal unsigned fixed point Q2.(W-2)
  localparam int W = MANT_W + PREC_W;

  // Round-to-nearest sqrt(2^e), evaluated at elaboration time
  function automatic logic [W-1:0] round_sqrt_pow2(input int e);
    logic [2*W-1:0] n, root, cand;
    n    = (2*W)'(1) << e;
    root = '0;
    for (int k = W-1; k >= 0; k--) begin
      cand = root | ((2*W)'(1) << k);
      if (cand * cand <= n) root = cand;
    end
    // (root+0.5)^2 = root^2 + root + 0.25
    if (n - root * root > root) root = root + 1'b1;
    return W'(root);
  endfunction

  localparam logic [W-1:0] ONE   = W'(1) << (W-2);
  localparam logic [W-1:0] THREE = W'(3) << (W-2);
  localparam logic [W-1:0] SQRT2 = round_sqrt_pow2(2*(W-2) + 1);
`ifdef SQRT_RSQRT_EN
  localparam logic [W-1:0] SQRT1_2 = round_sqrt_pow2(2*(W-2) - 1);
`endif

  // Fixed-point product, truncated back to W bits
  function automatic logic [W-1:0] qmul(input logic [W-1:0] a, input logic [W-1:0] c);
    logic [2*W-1:0] p;
    p = a * c;
    return W'(p >> (W-2));
  endfunction

  typedef enum logic [2:0] {IDLE, ST_B, ST_R, ST_XY, ST_FIN} state_t;
  state_t state, state_nxt;

  logic [W-1:0]  b, r, x;
  logic [IW-1:0] i;
  logic          odd_q;
`ifdef SQRT_RSQRT_EN
  logic [W-1:0]  y;
  logic          mode_q;
`else
  logic          unused_mode;
  assign unused_mode = mode_i;
`endif

  // Operand alignment and seed: r0 = (3 - s)/2, x0 = s*r0
  logic [W-1:0] s_ext, r0, x0;
  assign s_ext = W'(s_i) << (PREC_W-1);
  assign r0    = (THREE - s_ext) >> 1;
  assign x0    = qmul(s_ext, r0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (doSqrt_i) state_nxt = ST_B;
      ST_B:    state_nxt = (r == ONE || i == IW'(ITER_MAX)) ? ST_FIN : ST_R;
      ST_R:    state_nxt = ST_XY;
      ST_XY:   state_nxt = ST_B;
      ST_FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

  // Finalisation: select, odd-exponent scale, normalise, round
  logic [W-1:0]      v_sel, v_sc, v_n;
  logic [MANT_W:0]   top, sum;
  logic [MANT_W-1:0] res_c;
`ifdef SQRT_RSQRT_EN
  logic              norm_c;
`endif

  always_comb begin
    v_sel = x;
`ifdef SQRT_RSQRT_EN
    if (mode_q) v_sel = y;
`endif
    v_sc = v_sel;
    if (odd_q) begin
`ifdef SQRT_RSQRT_EN
      v_sc = qmul(v_sel, mode_q ? SQRT1_2 : SQRT2);
`else
      v_sc = qmul(v_sel, SQRT2);
`endif
    end
    v_n = v_sc;
`ifdef SQRT_RSQRT_EN
    norm_c = 1'b0;
    if (v_sc < ONE) begin
      v_n    = v_sc << 1;
      norm_c = 1'b1;
    end
`endif
    // top[MANT_W] set means v >= 2.0; treated like a rounding carry-out
    top   = (MANT_W+1)'(v_n >> (PREC_W-1));
    sum   = {1'b0, top[MANT_W-1:0]} + {{MANT_W{1'b0}}, v_n[PREC_W-2]};
    res_c = (top[MANT_W] || sum[MANT_W]) ? '1 : sum[MANT_W-1:0];
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      b       <= '0;
      r       <= '0;
      x       <= '0;
      i       <= '0;
      odd_q   <= 1'b0;
      valid_o <= 1'b0;
      res_o   <= '0;
      iter_o  <= '0;
`ifdef SQRT_RSQRT_EN
      y       <= '0;
      mode_q  <= 1'b0;
      norm_o  <= 1'b0;
`endif
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: if (doSqrt_i) begin
          b     <= s_ext;
          r     <= r0;
          x     <= x0;
          i     <= '0;
          odd_q <= is_exp_odd_i;
`ifdef SQRT_RSQRT_EN
          y      <= r0;
          mode_q <= mode_i;
`endif
        end
        ST_B:  if (state_nxt == ST_R) b <= qmul(b, qmul(r, r));
        ST_R:  r <= (THREE - b) >> 1;
        ST_XY: begin
          x <= qmul(x, r);
`ifdef SQRT_RSQRT_EN
          y <= qmul(y, r);
`endif
          i <= i + 1'b1;
        end
        ST_FIN: begin
          res_o   <= res_c;
          iter_o  <= i;
          valid_o <= 1'b1;
`ifdef SQRT_RSQRT_EN
          norm_o  <= norm_c;
`endif
        end
        default: ;
      endcase
    end
  end

`ifndef SQRT_RSQRT_EN
  // A sqrt of a value in [1,2) never drops below 1.0
  assign norm_o = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_goldschmidt_unit.sv
module tb_sqrt_goldschmidt_unit;
  localparam int MANT_W = 8;
  localparam int PREC_W = 8;
  localparam int F      = MANT_W + PREC_W - 2;
`ifdef SQRT_RSQRT_EN
  localparam bit RSQRT_EN = 1'b1;
`else
  localparam bit RSQRT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT (ITER_MAX = 4)
  logic       doSqrt = 0, odd = 0, mode = 0;
  logic [7:0] s = 8'h80;
  logic       busy, valid, norm;
  logic [7:0] res;
  logic [2:0] iter;

  sqrt_goldschmidt_unit #(.MANT_W(MANT_W), .PREC_W(PREC_W), .ITER_MAX(4)) dut (
    .clk(clk), .rst(rst), .doSqrt_i(doSqrt), .s_i(s), .is_exp_odd_i(odd),
    .mode_i(mode), .busy_o(busy), .valid_o(valid), .res_o(res),
    .norm_o(norm), .iter_o(iter));

  // iteration-cap DUT (ITER_MAX = 1)
  logic       do1 = 0, odd1 = 0, mode1 = 0;
  logic [7:0] s1 = 8'h80;
  logic       busy1, valid1, norm1;
  logic [7:0] res1;
  logic [0:0] iter1;

  sqrt_goldschmidt_unit #(.MANT_W(MANT_W), .PREC_W(PREC_W), .ITER_MAX(1)) dut1 (
    .clk(clk), .rst(rst), .doSqrt_i(do1), .s_i(s1), .is_exp_odd_i(odd1),
    .mode_i(mode1), .busy_o(busy1), .valid_o(valid1), .res_o(res1),
    .norm_o(norm1), .iter_o(iter1));

  int checks = 0;
  int errors = 0;
  int n_valid = 0;

  typedef struct {
    logic [7:0] res;
    bit         norm;
    int         iter;
    int         k;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask

  // Behavioural model: Goldschmidt recurrence on plain integers in Q2.F
  function automatic void model(input logic [7:0] sv_in, input bit o, input bit md,
                                input int imax, output logic [7:0] r_out,
                                output bit n_out, output int it);
    longint one, three, sv, b, r, x, y, v, r2, top, c;
    one   = longint'(1) << F;
    three = 3 * one;
    sv    = longint'(sv_in) << (PREC_W - 1);
    b = sv;
    r = (three - sv) / 2;
    y = r;
    x = (sv * r) >> F;
    it = 0;
    while (r != one && it < imax) begin
      r2 = (r * r) >> F;
      b  = (b * r2) >> F;
      r  = (three - b) / 2;
      x  = (x * r) >> F;
      y  = (y * r) >> F;
      it++;
    end
    v = md ? y : x;
    if (o) begin
      c = longint'($rtoi((md ? 0.7071067811865476 : 1.4142135623730951) * real'(one) + 0.5));
      v = (v * c) >> F;
    end
    n_out = 1'b0;
    if (RSQRT_EN && v < one) begin
      v = v * 2;
      n_out = 1'b1;
    end
    top = (v >> (PREC_W - 1)) + ((v >> (PREC_W - 2)) & 1);
    if (v >= 2 * one || top >= 256) r_out = 8'hFF;
    else                            r_out = top[7:0];
  endfunction

  // Monitor: pop and compare on every result strobe
  always @(negedge clk) begin
    if (!rst && valid) begin
      exp_t e;
      n_valid++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: res 0x%0h with no pending request at cycle %0d", res, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("res", res, e.res);
        chk("norm", norm, e.norm);
        chk("iter", iter, e.iter);
        chk("latency_edge", cyc, e.k + 3 * e.iter + 2);
      end
    end
  end

  // Issue one request when idle; called right after a negedge.
  // garbage: hold doSqrt one more cycle with other operands while busy.
  task automatic issue(input logic [7:0] sv, input bit o, input bit md,
                       input bit directed, input logic [7:0] dres, input bit dnorm,
                       input int diter, input bit garbage);
    exp_t e;
    int   guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: busy still 1 after %0d cycles", guard);
      return;
    end
    doSqrt = 1'b1;
    s      = sv;
    odd    = o;
    mode   = md;
    if (directed) begin
      e.res = dres; e.norm = dnorm; e.iter = diter;
    end else begin
      model(sv, o, RSQRT_EN ? md : 1'b0, 4, e.res, e.norm, e.iter);
    end
    e.k = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    if (garbage) begin
      s    = 8'h80 | 8'($urandom);
      odd  = 1'($urandom);
      mode = 1'($urandom);
      @(negedge clk);
    end
    doSqrt = 1'b0;
  endtask

  initial begin
    logic [7:0] er;
    bit         en;
    int         ei, k1, guard, nv0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_res", res, 0);
    chk("rst_norm", norm, 0);
    chk("rst_iter", iter, 0);
    chk("rst_busy1", busy1, 0);
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    issue(8'h80, 0, 0, 1, 8'h80, 0, 0, 0);  // trivial, N=0
    issue(8'h80, 1, 0, 1, 8'hB5, 0, 0, 0);  // odd exponent
    issue(8'hC8, 0, 0, 1, 8'hA0, 0, 4, 0);  // 1.5625 -> 1.25
`ifdef SQRT_RSQRT_EN
    issue(8'hC8, 0, 1, 1, 8'hCD, 1, 4, 0);  // 1/sqrt(1.5625) = 0.8 -> 1.6
`else
    issue(8'hC8, 0, 1, 1, 8'hA0, 0, 4, 0);  // mode ignored
`endif
    issue(8'hC8, 0, 0, 1, 8'hA0, 0, 4, 1);  // request while busy ignored

    // randomized traffic, including back-to-back and ignored requests
    for (int n = 0; n < 150; n++) begin
      issue(8'h80 | 8'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0, 0,
            ($urandom % 4) == 0);
      repeat ($urandom % 3) @(negedge clk);
    end

    // drain
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", exp_q.size(), 0);

    // iteration cap on the ITER_MAX=1 instance
    do1 = 1'b1; s1 = 8'hFF; odd1 = 1'b0; mode1 = 1'b0;
    k1 = cyc + 1;
    @(negedge clk);
    do1 = 1'b0;
    guard = 0;
    while (!valid1 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    chk("cap_valid_seen", valid1, 1);
    chk("cap_latency_edge", cyc, k1 + 5);
    chk("cap_iter", iter1, 1);
    model(8'hFF, 0, 0, 1, er, en, ei);
    chk("cap_res", res1, er);
    @(negedge clk);

    // reset while in R aborts without a result
    issue(8'hC8, 0, 0, 0, 0, 0, 0, 0);      // returns with state B
    @(negedge clk);                         // state R
    rst = 1'b1;
    exp_q.delete();
    nv0 = n_valid;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_res", res, 0);
    chk("abort_iter", iter, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_valid", n_valid, nv0);

    // operation after abort still works
    issue(8'h80, 1, 0, 1, 8'hB5, 0, 0, 0);
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("post_abort_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
